// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
package hazard_pkg;

  typedef enum logic [2:0] {
    FWD_PC8_M = 3'b000,
    FWD_ALU_M = 3'b001,
    FWD_RES_W = 3'b010,
    FWD_RF    = 3'b011
  } fwd_sel_t;

  typedef enum logic [1:0] {
    SRC_PC8 = 2'b00,
    SRC_ALU = 2'b01,
    SRC_MEM = 2'b10
  } src_t;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef struct packed {
    logic [4:0] a3;
    logic [1:0] tnew;
    src_t       src;
  } stage_tag_t;

  localparam stage_tag_t TAG_BUBBLE = '{a3: 5'd0, tnew: 2'd0, src: SRC_PC8};

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // Producer in a stage will not have its value ready by the time the reader needs it.
  function automatic logic late_hit(input logic [4:0] r, input logic [1:0] tuse,
                                    input stage_tag_t t);
    return (r != 5'd0) && (t.a3 == r) && (tuse != TUSE_NONE) && (t.tnew > tuse);
  endfunction

  // M wins over W; an M hit is only taken once its value exists (tnew == 0).
  function automatic fwd_sel_t fwd_select(input logic [4:0] r, input stage_tag_t m,
                                          input stage_tag_t w);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (r != 5'd0 && m.a3 == r && m.tnew == 2'd0)
      sel = (m.src == SRC_PC8) ? FWD_PC8_M : FWD_ALU_M;
    else if (r != 5'd0 && w.a3 == r)
      sel = FWD_RES_W;
    return sel;
  endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// Mult/div occupancy countdown; loads the latency when an op advances into E.
module md_busy_tracker
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10,
  parameter int unsigned CNT_W    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic issue,
  input  logic is_div,
  output logic md_start_e,
  output logic md_busy
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      md_start_e <= 1'b0;
    end else begin
      md_start_e <= issue;
      if (issue)
        cnt <= is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
      else if (cnt != '0)
        cnt <= cnt - CNT_W'(1);
    end
  end

  assign md_busy = (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall/forwarding controller for the 5-stage pipeline; tracks destination
// tags through E, M and W and owns the mult/div busy interlock.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] tuse_rs_D,
  input  logic [1:0] tuse_rt_D,
  input  logic [4:0] a3_D,
  input  logic [1:0] tnew_D,
  input  logic [1:0] src_D,
  input  logic       md_start_D,
  input  logic       md_div_D,
  input  logic       md_use_D,
  output logic       stall,
  output logic [2:0] FSelRS_D,
  output logic [2:0] FSelRT_D,
  output logic [2:0] FSel1_E,
  output logic [2:0] FSel2_E,
  output logic       FSelWD_M,
  output logic       md_busy
);

  stage_tag_t tag_d, tag_e, tag_m, tag_w;
  logic [4:0] rs_e, rt_e, rt_m;
  logic       md_start_e;
  logic       issue;

  assign tag_d = '{a3: a3_D, tnew: tnew_D, src: src_t'(src_D)};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_e <= TAG_BUBBLE;
      tag_m <= TAG_BUBBLE;
      tag_w <= TAG_BUBBLE;
      rs_e  <= '0;
      rt_e  <= '0;
      rt_m  <= '0;
    end else begin
      if (stall) begin
        tag_e <= TAG_BUBBLE;
        rs_e  <= '0;
        rt_e  <= '0;
      end else begin
        tag_e <= tag_d;
        rs_e  <= rs_D;
        rt_e  <= rt_D;
      end
      tag_m <= '{a3: tag_e.a3, tnew: tnew_dec(tag_e.tnew), src: tag_e.src};
      rt_m  <= rt_e;
      tag_w <= '{a3: tag_m.a3, tnew: 2'd0, src: tag_m.src};
    end
  end

  // md_start_e covers the edge where the counter is loading but not yet visible as busy.
  always_comb begin
    stall = 1'b0;
    if (late_hit(rs_D, tuse_rs_D, tag_e) || late_hit(rs_D, tuse_rs_D, tag_m) ||
        late_hit(rt_D, tuse_rt_D, tag_e) || late_hit(rt_D, tuse_rt_D, tag_m))
      stall = 1'b1;
    if ((md_busy || md_start_e) && (md_use_D || md_start_D))
      stall = 1'b1;
  end

  assign FSelRS_D = fwd_select(rs_D, tag_m, tag_w);
  assign FSelRT_D = fwd_select(rt_D, tag_m, tag_w);
  assign FSel1_E  = fwd_select(rs_e, tag_m, tag_w);
  assign FSel2_E  = fwd_select(rt_e, tag_m, tag_w);
  assign FSelWD_M = (rt_m != 5'd0) && (tag_w.a3 == rt_m);

  assign issue = md_start_D && !stall;

  md_busy_tracker #(
    .MULT_LAT(MULT_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_md_busy (
    .clk       (clk),
    .reset     (reset),
    .issue     (issue),
    .is_div    (md_div_D),
    .md_start_e(md_start_e),
    .md_busy   (md_busy)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed instruction streams with hand-derived
// expected stall/forward/busy values, checked by a separate monitor.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_D, rt_D, a3_D;
  logic [1:0] tuse_rs_D, tuse_rt_D, tnew_D, src_D;
  logic       md_start_D, md_div_D, md_use_D;
  logic       stall, FSelWD_M, md_busy;
  logic [2:0] FSelRS_D, FSelRT_D, FSel1_E, FSel2_E;

  always #5 clk = ~clk;

  hazard_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .a3_D(a3_D), .tnew_D(tnew_D), .src_D(src_D),
    .md_start_D(md_start_D), .md_div_D(md_div_D), .md_use_D(md_use_D),
    .stall(stall), .FSelRS_D(FSelRS_D), .FSelRT_D(FSelRT_D),
    .FSel1_E(FSel1_E), .FSel2_E(FSel2_E), .FSelWD_M(FSelWD_M), .md_busy(md_busy)
  );

  localparam logic [2:0] S_PC8 = 3'd0, S_ALU = 3'd1, S_RES = 3'd2, S_RF = 3'd3;
  localparam logic [6:0] K_ST = 7'h01, K_RSD = 7'h02, K_RTD = 7'h04, K_F1 = 7'h08,
                         K_F2 = 7'h10, K_WD = 7'h20, K_BZ = 7'h40, K_ALL = 7'h7f;

  typedef struct packed {
    logic [4:0] rs, rt;
    logic [1:0] trs, trt;
    logic [4:0] a3;
    logic [1:0] tnew, src;
    logic       st, dv, us;
  } instr_t;

  typedef struct {
    string      name;
    logic [6:0] m;
    logic       st;
    logic [2:0] rsd, rtd, f1, f2;
    logic       wd, bz;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  event sample_ev;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic instr_t mk_i(input logic [4:0] rs, rt, input logic [1:0] trs, trt,
                                  input logic [4:0] a3, input logic [1:0] tnew, src,
                                  input logic st, dv, us);
    instr_t i;
    i.rs = rs; i.rt = rt; i.trs = trs; i.trt = trt; i.a3 = a3;
    i.tnew = tnew; i.src = src; i.st = st; i.dv = dv; i.us = us;
    return i;
  endfunction

  function automatic instr_t nop();
    return mk_i(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic instr_t alu(input logic [4:0] rd, rs, rt);
    return mk_i(rs, rt, 2'd1, 2'd1, rd, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic instr_t lw(input logic [4:0] rt, base);
    return mk_i(base, rt, 2'd1, 2'd3, rt, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic instr_t sw(input logic [4:0] rt, base);
    return mk_i(base, rt, 2'd1, 2'd2, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic instr_t jal();
    return mk_i(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic instr_t beq(input logic [4:0] rs, rt);
    return mk_i(rs, rt, 2'd0, 2'd0, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic instr_t mdop(input logic is_div);
    return mk_i(5'd1, 5'd2, 2'd1, 2'd1, 5'd0, 2'd0, 2'd0, 1'b1, is_div, 1'b0);
  endfunction
  function automatic instr_t mflo(input logic [4:0] rd);
    return mk_i(5'd0, 5'd0, 2'd3, 2'd3, rd, 2'd1, 2'd1, 1'b0, 1'b0, 1'b1);
  endfunction

  function automatic exp_t ex(input string n, input logic [6:0] m, input logic st,
                              input logic [2:0] rsd, rtd, f1, f2, input logic wd, bz);
    exp_t e;
    e.name = n; e.m = m; e.st = st; e.rsd = rsd; e.rtd = rtd;
    e.f1 = f1; e.f2 = f2; e.wd = wd; e.bz = bz;
    return e;
  endfunction
  function automatic exp_t dc();
    return ex("idle", 7'h00, 1'b0, S_RF, S_RF, S_RF, S_RF, 1'b0, 1'b0);
  endfunction

  task automatic drive(input instr_t i);
    rs_D = i.rs; rt_D = i.rt; tuse_rs_D = i.trs; tuse_rt_D = i.trt;
    a3_D = i.a3; tnew_D = i.tnew; src_D = i.src;
    md_start_D = i.st; md_div_D = i.dv; md_use_D = i.us;
  endtask

  task automatic step(input instr_t i, input exp_t e);
    drive(i);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    repeat (3) step(nop(), dc());
  endtask

  task automatic cmp(input string n, input string f, input logic [2:0] act, input logic [2:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s.%s: got %0d, expected %0d at %0t", n, f, act, req, $time);
    end
  endtask

  always @(negedge clk or sample_ev) begin
    if (sb.size() > 0) begin
      me = sb.pop_front();
      if (me.m[0]) cmp(me.name, "stall",    {2'b0, stall},    {2'b0, me.st});
      if (me.m[1]) cmp(me.name, "FSelRS_D", FSelRS_D,         me.rsd);
      if (me.m[2]) cmp(me.name, "FSelRT_D", FSelRT_D,         me.rtd);
      if (me.m[3]) cmp(me.name, "FSel1_E",  FSel1_E,          me.f1);
      if (me.m[4]) cmp(me.name, "FSel2_E",  FSel2_E,          me.f2);
      if (me.m[5]) cmp(me.name, "FSelWD_M", {2'b0, FSelWD_M}, {2'b0, me.wd});
      if (me.m[6]) cmp(me.name, "md_busy",  {2'b0, md_busy},  {2'b0, me.bz});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    drive(nop());
    @(posedge clk);
    #1;
    sb.push_back(ex("reset", K_ALL, 1'b0, S_RF, S_RF, S_RF, S_RF, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Load-use: one stall for an E-stage consumer, then Result_W forward.
    step(lw(5'd8, 5'd29), ex("ld_issue", K_ST, 1'b0, S_RF, S_RF, S_RF, S_RF, 1'b0, 1'b0));
    step(alu(5'd9, 5'd8, 5'd8), ex("ld_stall", K_ST | K_RSD | K_RTD, 1'b1, S_RF, S_RF, S_RF, S_RF, 1'b0, 1'b0));
    step(alu(5'd9, 5'd8, 5'd8), ex("ld_release", K_ST | K_RSD | K_F1 | K_F2 | K_WD, 1'b0, S_RF, S_RF, S_RF, S_RF, 1'b0, 1'b0));
    step(nop(), ex("ld_fwd_e", K_ST | K_F1 | K_F2, 1'b0, S_RF, S_RF, S_RES, S_RES, 1'b0, 1'b0));

    // Load feeding a D-stage compare: two stalls.
    flush();
    step(lw(5'd8, 5'd29), dc());
    step(beq(5'd8, 5'd0), ex("lb_stall1", K_ST, 1'b1, S_RF, S_RF, S_RF, S_RF, 1'b0, 1'b0));
    step(beq(5'd8, 5'd0), ex("lb_stall2", K_ST | K_RSD, 1'b1, S_RF, S_RF, S_RF, S_RF, 1'b0, 1'b0));
    step(beq(5'd8, 5'd0), ex("lb_go", K_ST | K_RSD | K_RTD, 1'b0, S_RES, S_RF, S_RF, S_RF, 1'b0, 1'b0));

    // ALU chain, back-to-back.
    flush();
    step(alu(5'd3, 5'd1, 5'd2), dc());
    step(alu(5'd4, 5'd3, 5'd5), ex("alu_nostall", K_ST | K_RSD, 1'b0, S_RF, S_RF, S_RF, S_RF, 1'b0, 1'b0));
    step(nop(), ex("alu_fwd_m", K_ST | K_F1 | K_F2, 1'b0, S_RF, S_RF, S_ALU, S_RF, 1'b0, 1'b0));

    // ALU chain with one instruction between.
    flush();
    step(alu(5'd3, 5'd1, 5'd2), dc());
    step(alu(5'd6, 5'd7, 5'd7), dc());
    step(alu(5'd4, 5'd3, 5'd5), ex("alu_d_fwd", K_ST | K_RSD, 1'b0, S_ALU, S_RF, S_RF, S_RF, 1'b0, 1'b0));
    step(nop(), ex("alu_fwd_w", K_F1 | K_F2, 1'b0, S_RF, S_RF, S_RES, S_RF, 1'b0, 1'b0));

    // Same register in M and W; identical rs/rt.
    flush();
    step(alu(5'd3, 5'd1, 5'd2), dc());
    step(alu(5'd3, 5'd1, 5'd2), dc());
    step(alu(5'd4, 5'd3, 5'd3), ex("prio_d", K_ST | K_RSD | K_RTD, 1'b0, S_ALU, S_ALU, S_RF, S_RF, 1'b0, 1'b0));
    step(nop(), ex("prio_e", K_F1 | K_F2, 1'b0, S_RF, S_RF, S_ALU, S_ALU, 1'b0, 1'b0));

    // jal link register into branch compare.
    flush();
    step(jal(), dc());
    step(beq(5'd31, 5'd0), ex("jal_e", K_ST | K_RSD, 1'b0, S_RF, S_RF, S_RF, S_RF, 1'b0, 1'b0));
    step(beq(5'd31, 5'd31), ex("jal_m", K_ST | K_RSD | K_RTD | K_F1, 1'b0, S_PC8, S_PC8, S_PC8, S_RF, 1'b0, 1'b0));
    step(nop(), ex("jal_w", K_F1 | K_F2, 1'b0, S_RF, S_RF, S_RES, S_RES, 1'b0, 1'b0));

    // Register zero never hazards or forwards.
    flush();
    step(alu(5'd0, 5'd1, 5'd2), dc());
    step(alu(5'd5, 5'd0, 5'd0), ex("r0_d", K_ST | K_RSD | K_RTD, 1'b0, S_RF, S_RF, S_RF, S_RF, 1'b0, 1'b0));
    step(nop(), ex("r0_e", K_ALL, 1'b0, S_RF, S_RF, S_RF, S_RF, 1'b0, 1'b0));

    // Store data forwarding.
    flush();
    step(alu(5'd7, 5'd1, 5'd2), dc());
    step(sw(5'd7, 5'd29), ex("st_nostall", K_ST, 1'b0, S_RF, S_RF, S_RF, S_RF, 1'b0, 1'b0));
    step(nop(), ex("st_fwd_e", K_F2, 1'b0, S_RF, S_RF, S_RF, S_ALU, 1'b0, 1'b0));
    step(nop(), ex("st_wd", K_WD, 1'b0, S_RF, S_RF, S_RF, S_RF, 1'b1, 1'b0));
    step(nop(), ex("st_wd_off", K_WD, 1'b0, S_RF, S_RF, S_RF, S_RF, 1'b0, 1'b0));

    // Divide then mflo: ten stall cycles.
    flush();
    step(mdop(1'b1), ex("div_issue", K_ST | K_BZ, 1'b0, S_RF, S_RF, S_RF, S_RF, 1'b0, 1'b0));
    repeat (10) step(mflo(5'd9), ex("div_stall", K_ST | K_BZ, 1'b1, S_RF, S_RF, S_RF, S_RF, 1'b0, 1'b1));
    step(mflo(5'd9), ex("div_done", K_ST | K_BZ, 1'b0, S_RF, S_RF, S_RF, S_RF, 1'b0, 1'b0));

    // Multiply then mflo: five stall cycles.
    flush();
    step(mdop(1'b0), ex("mul_issue", K_ST | K_BZ, 1'b0, S_RF, S_RF, S_RF, S_RF, 1'b0, 1'b0));
    repeat (5) step(mflo(5'd9), ex("mul_stall", K_ST | K_BZ, 1'b1, S_RF, S_RF, S_RF, S_RF, 1'b0, 1'b1));
    step(mflo(5'd9), ex("mul_done", K_ST | K_BZ, 1'b0, S_RF, S_RF, S_RF, S_RF, 1'b0, 1'b0));

    // A new mult/div waits for the unit; non-MDU work does not.
    flush();
    step(mdop(1'b0), dc());
    repeat (5) step(mdop(1'b1), ex("md_md_stall", K_ST, 1'b1, S_RF, S_RF, S_RF, S_RF, 1'b0, 1'b1));
    step(mdop(1'b1), ex("md_md_go", K_ST | K_BZ, 1'b0, S_RF, S_RF, S_RF, S_RF, 1'b0, 1'b0));
    step(nop(), ex("md_nop_busy", K_ST | K_BZ, 1'b0, S_RF, S_RF, S_RF, S_RF, 1'b0, 1'b1));
    repeat (12) step(nop(), dc());

    // Asynchronous reset in the middle of a divide (count at 7).
    step(mdop(1'b1), dc());
    step(alu(5'd3, 5'd1, 5'd2), ex("rst_prep", K_ST | K_BZ, 1'b0, S_RF, S_RF, S_RF, S_RF, 1'b0, 1'b1));
    step(alu(5'd4, 5'd3, 5'd3), dc());
    step(mflo(5'd9), ex("rst_stall", K_ST, 1'b1, S_RF, S_RF, S_RF, S_RF, 1'b0, 1'b1));
    drive(mflo(5'd9));
    sb.push_back(ex("rst_pre", K_ST | K_WD | K_BZ, 1'b1, S_RF, S_RF, S_RF, S_RF, 1'b1, 1'b1));
    @(negedge clk);
    #2;
    reset = 1'b1;
    sb.push_back(ex("rst_async", K_ALL, 1'b0, S_RF, S_RF, S_RF, S_RF, 1'b0, 1'b0));
    #1;
    ->sample_ev;
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(mflo(5'd9), ex("rst_after", K_ST | K_BZ, 1'b0, S_RF, S_RF, S_RF, S_RF, 1'b0, 1'b0));
    drive(nop());

    repeat (2) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
